// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: single-outstanding request fetcher with a one-entry
// output buffer toward the decoder and redirect/flush handling.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instruction,
  output logic [31:0] out_pc,
  output logic [31:0] fetch_count
);

  // state | meaning
  // REQ   | no request outstanding, may issue
  // WAIT  | one request outstanding, response will be forwarded
  // DROP  | one request outstanding, response is stale and will be discarded
  localparam logic [1:0] ST_REQ  = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  logic [1:0]  state;
  // Word addresses only; the byte offset is always zero.
  logic [31:2] pc;
  logic [31:2] inflight_pc;
  logic        req_fire;
  logic        resp_take;
  logic        out_fire;
  logic        unused_bits;

  assign unused_bits = ^redirect_pc[1:0];

  // Request only when the output buffer is free (or draining this cycle).
  assign imem_req_valid = (state == ST_REQ) && !redirect_valid &&
                          (!out_valid || out_ready) && !rst;
  assign imem_addr      = {pc, 2'b00};
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign resp_take      = (state == ST_WAIT) && imem_resp_valid && !redirect_valid;
  assign out_fire       = out_valid && out_ready;

  // Request tracking state machine.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_REQ;
      inflight_pc <= '0;
    end else begin
      case (state)
        ST_REQ: begin
          if (req_fire) begin
            inflight_pc <= pc;
            state       <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (redirect_valid) begin
            state <= imem_resp_valid ? ST_REQ : ST_DROP;
          end else if (imem_resp_valid) begin
            state <= ST_REQ;
          end
        end
        ST_DROP: begin
          if (imem_resp_valid) begin
            state <= ST_REQ;
          end
        end
        default: state <= ST_REQ;
      endcase
    end
  end

  // Program counter and output buffer; a redirect flushes the buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc              <= RESET_PC[31:2];
      out_valid       <= 1'b0;
      out_instruction <= '0;
      out_pc          <= '0;
    end else begin
      if (redirect_valid) begin
        pc        <= redirect_pc[31:2];
        out_valid <= 1'b0;
      end else if (resp_take) begin
        pc              <= inflight_pc + 30'd1;
        out_valid       <= 1'b1;
        out_instruction <= imem_rdata;
        out_pc          <= {inflight_pc, 2'b00};
      end else if (out_fire) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Delivered-instruction counter; a handshake during a flush still counts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count <= '0;
    end else if (out_fire) begin
      fetch_count <= fetch_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios followed by random traffic,
// all compared each cycle against a transaction-level model.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instruction;
  logic [31:0] out_pc;
  logic [31:0] fetch_count;

  int checks = 0;
  int failures = 0;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr), .imem_resp_valid(imem_resp_valid),
    .imem_rdata(imem_rdata), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_instruction(out_instruction), .out_pc(out_pc),
    .fetch_count(fetch_count)
  );

  // clock generator
  always #5 clk = ~clk;

  // Model: fetch pointer, one optional outstanding request (live or stale),
  // one optional buffered instruction, delivered count.
  logic [31:0] m_pc = 32'h0;
  bit          m_out = 0;
  bit          m_stale = 0;
  logic [31:0] m_ipc = '0;
  bit          m_bv = 0;
  logic [31:0] m_bi = '0;
  logic [31:0] m_bp = '0;
  logic [31:0] m_cnt = '0;

  // Memory: one pending response slot with configurable latency.
  bit          mem_pend = 0;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = '0;
  int          mem_lat_cfg = 1;
  bit          mem_const = 1;

  // Observations captured at the sampling point of the last step.
  logic        obs_req;
  logic [31:0] obs_addr;
  logic        obs_ov;
  logic        obs_deliv;
  logic [31:0] obs_pc;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return mem_const ? 32'h0000_0013 : (a ^ 32'hC0DE_0013);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_out = 0; m_stale = 0; m_ipc = '0;
    m_bv = 0; m_bi = '0; m_bp = '0; m_cnt = '0;
  endtask

  // One clock cycle: drive inputs, compare at negedge, advance model/memory.
  task automatic step(input bit rdy, input bit ordy, input bit redir, input logic [31:0] rpc);
    bit          resp;
    bit          m_req;
    logic [31:0] rd;
    logic [31:0] req_pc;
    int          lat;
    resp = mem_pend && (mem_cnt == 0);
    rd   = resp ? mem_data(mem_addr) : $urandom;
    imem_req_ready  = rdy;
    out_ready       = ordy;
    redirect_valid  = redir;
    redirect_pc     = rpc;
    imem_resp_valid = resp;
    imem_rdata      = rd;
    if (rst) model_reset();
    @(negedge clk);
    m_req = !rst && !m_out && !redir && (!m_bv || ordy);
    chk("imem_req_valid", {31'd0, imem_req_valid}, {31'd0, m_req});
    if (m_req) chk("imem_addr", imem_addr, m_pc);
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_bv});
    chk("out_instruction", out_instruction, m_bi);
    chk("out_pc", out_pc, m_bp);
    chk("fetch_count", fetch_count, m_cnt);
    obs_req = imem_req_valid; obs_addr = imem_addr; obs_ov = out_valid;
    obs_deliv = out_valid && out_ready; obs_pc = out_pc;
    req_pc = m_pc;
    if (!rst) begin
      if (m_bv && ordy) m_cnt++;
      if (redir) begin
        if (m_out && resp) begin m_out = 0; m_stale = 0; end
        else if (m_out) m_stale = 1;
        m_pc = {rpc[31:2], 2'b00};
        m_bv = 0;
      end else begin
        if (m_bv && ordy) m_bv = 0;
        if (m_out && resp) begin
          if (!m_stale) begin
            m_bv = 1; m_bi = rd; m_bp = m_ipc; m_pc = m_ipc + 32'd4;
          end
          m_out = 0; m_stale = 0;
        end else if (m_req && rdy) begin
          m_out = 1; m_ipc = m_pc;
        end
      end
    end
    if (resp) mem_pend = 0;
    else if (mem_pend) mem_cnt--;
    if (m_req && rdy) begin
      lat = (mem_lat_cfg == 0) ? int'($urandom_range(3, 1)) : mem_lat_cfg;
      mem_pend = 1; mem_addr = req_pc; mem_cnt = lat - 1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] pcs [3];
    int          nd;
    logic [6:0]  ov_hist;
    int          nreq;
    logic [31:0] held_pc;
    logic [31:0] held_instr;

    // Reset state
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_fetch_count", fetch_count, 32'd0);
    chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_instruction", out_instruction, 32'd0);

    // Steady stream: 1-cycle memory, decoder always ready
    rst = 1'b0;
    nd = 0; ov_hist = '0;
    for (int i = 0; i < 7; i++) begin
      step(1, 1, 0, 0);
      if (i == 0) begin
        chk("first_req_valid", {31'd0, obs_req}, 32'd1);
        chk("first_req_addr", obs_addr, 32'h0);
      end
      ov_hist = {ov_hist[5:0], obs_ov};
      if (obs_deliv && nd < 3) begin pcs[nd] = obs_pc; nd++; end
    end
    chk("stream_deliveries", nd, 32'd3);
    chk("stream_pc0", pcs[0], 32'h0);
    chk("stream_pc1", pcs[1], 32'h4);
    chk("stream_pc2", pcs[2], 32'h8);
    chk("stream_out_valid_pattern", {25'd0, ov_hist}, 32'b0010101);
    chk("stream_fetch_count", fetch_count, 32'd3);
    chk("model_count_pin", m_cnt, 32'd3);

    // Decoder stall: buffer must hold and no new request may go out
    step(1, 1, 0, 0);
    held_pc = out_pc; held_instr = out_instruction;
    chk("stall_out_pc_start", held_pc, 32'hC);
    nreq = 0;
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0, 0);
      if (obs_req) nreq++;
      chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_out_pc", out_pc, 32'hC);
      chk("stall_out_instruction", out_instruction, 32'h0000_0013);
    end
    chk("stall_req_count", nreq, 32'd0);
    step(1, 1, 0, 0);
    chk("stall_release_req", {31'd0, obs_req}, 32'd1);
    chk("stall_release_addr", obs_addr, 32'h10);

    // Redirect during WAIT, response arrives a cycle later and is dropped
    mem_const = 0;
    rst = 1'b1;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    rst = 1'b0;
    mem_lat_cfg = 1;
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0);
    mem_lat_cfg = 2;
    step(1, 1, 0, 0);
    chk("drop_req_addr8", obs_addr, 32'h8);
    mem_lat_cfg = 1;
    step(1, 1, 1, 32'h0000_0103);
    step(1, 1, 0, 0);
    chk("drop_no_out", {31'd0, out_valid}, 32'd0);
    step(1, 1, 0, 0);
    chk("redir_req_valid", {31'd0, obs_req}, 32'd1);
    chk("redir_req_addr", obs_addr, 32'h100);
    step(1, 1, 0, 0);
    chk("redir_out_valid", {31'd0, out_valid}, 32'd1);
    chk("redir_out_pc", out_pc, 32'h100);

    // Redirect coinciding with the response
    step(1, 1, 0, 0);
    step(1, 1, 1, 32'h0000_0200);
    chk("same_cycle_out_valid", {31'd0, out_valid}, 32'd0);
    step(1, 1, 0, 0);
    chk("same_cycle_req_valid", {31'd0, obs_req}, 32'd1);
    chk("same_cycle_req_addr", obs_addr, 32'h200);
    step(1, 1, 0, 0);
    chk("same_cycle_out_pc", out_pc, 32'h200);

    // Reset pulse while a request is outstanding
    mem_lat_cfg = 2;
    step(1, 1, 0, 0);
    mem_lat_cfg = 1;
    rst = 1'b1;
    step(1, 1, 0, 0);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_out_pc", out_pc, 32'd0);
    chk("midrst_out_instruction", out_instruction, 32'd0);
    chk("midrst_fetch_count", fetch_count, 32'd0);
    rst = 1'b0;
    step(1, 0, 0, 0);
    chk("postrst_req_valid", {31'd0, obs_req}, 32'd1);
    chk("postrst_req_addr", obs_addr, 32'h0);
    step(1, 0, 0, 0);
    chk("postrst_out_valid", {31'd0, out_valid}, 32'd1);
    chk("postrst_out_pc", out_pc, 32'h0);
    chk("postrst_out_instruction", out_instruction, 32'hC0DE_0013);

    // Counter wrap
    force dut.fetch_count = 32'hFFFF_FFFF;
    #1;
    release dut.fetch_count;
    m_cnt = 32'hFFFF_FFFF;
    step(1, 1, 0, 0);
    chk("wrap_fetch_count", fetch_count, 32'h0);

    // Random traffic
    mem_lat_cfg = 0;
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(9, 0) < 7), ($urandom_range(9, 0) < 6),
           ($urandom_range(15, 0) == 0), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port imem_req_valid  output  1  fetch request valid.
REQ-005 SHALL have port imem_req_ready  input  1  memory accepts request.
REQ-006 SHALL have port imem_addr  output  32  fetch address, bits [1:0] always 2'b00.
REQ-007 SHALL have port imem_resp_valid  input  1  response data valid (one cycle per accepted request).
REQ-008 SHALL have port imem_rdata  input  32  fetched instruction word.
REQ-009 SHALL have port redirect_valid  input  1  branch/jump redirect from execute, one-cycle pulse.
REQ-010 SHALL have port redirect_pc  input  32  redirect target; bits [1:0] ignored (forced 2'b00).
REQ-011 SHALL have port out_valid  output  1  instruction for the decoder valid.
REQ-012 SHALL have port out_ready  input  1  decoder accepts instruction.
REQ-013 SHALL have port out_instruction  output  32  instruction word to decoder.
REQ-014 SHALL have port out_pc  output  32  address of out_instruction.
REQ-015 SHALL have port fetch_count  output  32  count of instructions delivered (out_valid && out_ready), wraps 0xFFFF_FFFF -> 0.

Function
REQ-016 SHALL implement states REQ (may issue), WAIT (one request outstanding), DROP (stale response pending); at most one outstanding request.
REQ-017 SHALL drive imem_req_valid = (state==REQ) && !redirect_valid && (!out_valid || out_ready) && !rst.
REQ-018 SHALL drive imem_addr = pc register whenever imem_req_valid is high.
REQ-019 SHALL, on imem_req_valid && imem_req_ready, latch inflight_pc <= pc and go REQ -> WAIT.
REQ-020 SHALL, in WAIT with imem_resp_valid and no redirect, load out_instruction <= imem_rdata, out_pc <= inflight_pc, out_valid <= 1, pc <= inflight_pc + 4 (mod 2^32), go WAIT -> REQ.
REQ-021 SHALL clear out_valid on out_valid && out_ready unless REQ-020 reloads it the same edge.
REQ-022 SHALL hold out_instruction/out_pc stable while out_valid && !out_ready.
REQ-023 SHALL, on redirect_valid, set pc <= {redirect_pc[31:2],2'b00} and clear out_valid (flush), overriding REQ-020/REQ-021.
REQ-024 SHALL, on redirect in WAIT without imem_resp_valid, go WAIT -> DROP; with imem_resp_valid the same cycle, discard the data and go WAIT -> REQ.
REQ-025 SHALL, in DROP, discard the next imem_resp_valid and go DROP -> REQ; a redirect in DROP updates pc and stays DROP (or goes REQ if the response arrives that cycle).
REQ-026 SHALL, on redirect in REQ, suppress the request that cycle and stay REQ.
REQ-027 SHALL count an out handshake coinciding with a redirect as delivered (fetch_count increments).
REQ-028 SHALL ignore imem_resp_valid in REQ.
REQ-029 SHALL deliver at steady state one instruction per 2 cycles with 1-cycle memory latency (request cycle, response cycle).

Reset
REQ-030 SHALL, while rst high, hold state=REQ, pc=RESET_PC, inflight_pc=0, out_valid=0, out_instruction=0, out_pc=0, fetch_count=0, imem_req_valid=0.
REQ-031 SHALL, on rst asserted mid-operation, abandon any outstanding request and not forward its response after reset release.
REQ-032 SHALL issue the first request (imem_addr=RESET_PC) in the first cycle after rst deasserts, given out buffer empty.

Verification
REQ-033 Bench SHALL cover: release reset, ready=1, 1-cycle memory returning 0x00000013 -> out_pc 0x0,0x4,0x8 in order, out_valid every other cycle, fetch_count 3.
REQ-034 Bench SHALL cover: out_ready=0 for 5 cycles after first delivery -> out_valid held, out_instruction/out_pc unchanged, no second imem request issued.
REQ-035 Bench SHALL cover: redirect_pc=0x00000103 during WAIT for addr 0x8, response 2 cycles later -> response dropped, next imem_addr=0x00000100, next out_pc=0x100.
REQ-036 Bench SHALL cover: redirect and imem_resp_valid same cycle -> data discarded, out_valid=0 next cycle, next request addr = redirect target.
REQ-037 Bench SHALL cover: rst pulse while WAIT -> all outputs reset values, first post-reset request addr=RESET_PC, late stale response not forwarded.
REQ-038 Bench SHALL cover: fetch_count preloaded via force to 0xFFFF_FFFF, one delivery -> fetch_count 0x0000_0000.
